jtag_dp_tap: RTL and testbench
==============================

Name: jtag_dp_tap

Overview:
JTAG-DP responder: the target-side counterpart of the ADIv5 JTAG debug master. It oversamples TCK/TMS/TDI in the CLK domain and runs a standard 16-state TAP with a 4-bit IR (ABORT/DPACC/APACC/IDCODE/BYPASS). DPACC/APACC scans become register requests on a valid/ready backend port, which is an AP/DP register model or a bridge to an on-chip bus. Used for loopback regression of the remote bridge and as an FPGA-side debug target.

Parameters:
IDCODE, 32'h4BA00477, value captured in IDCODE DR; bit0 must be 1.
SYNC_STAGES, 2, synchronizer depth for TCK/TMS/TDI, minimum 2.

Ports:
CLK  in  1  system clock; must be at least 4x TCK.
RESET  in  1  synchronous, active-high reset.
TCK  in  1  JTAG clock, asynchronous.
TMS  in  1  JTAG mode select, asynchronous.
TDI  in  1  JTAG data in, asynchronous.
TDO  out  1  JTAG data out.
TDO_OE  out  1  high only in Shift-IR and Shift-DR.
REQ_VALID  out  1  backend request valid.
REQ_READY  in  1  backend accepts request.
REQ_APNDP  out  1  1=AP, 0=DP.
REQ_ADDR  out  2  A[3:2].
REQ_RNW  out  1  1=read.
REQ_WDATA  out  32  write data.
RSP_VALID  in  1  one-cycle pulse completing the outstanding request.
RSP_RDATA  in  32  read data, qualified by RSP_VALID.
RSP_ERR  in  1  request faulted, qualified by RSP_VALID.
ABORT_VALID  out  1  one-cycle pulse on ABORT Update-DR.
ABORT_DATA  out  5  ABORT DR bits [7:3], i.e. abort word [4:0].
STICKY_ERR  out  1  set by RSP_ERR; cleared by ABORT with word bit2.
TAP_RESET  out  1  one-cycle pulse on entry to Test-Logic-Reset.

Behaviour:
- Reset values: TDO=0, TDO_OE=0, REQ_*=0, ABORT_*=0, STICKY_ERR=0, TAP_RESET=0; TAP state=Test-Logic-Reset; IR=4'hE; pending=0; discard=0; result=0.
- Input sync: SYNC_STAGES flops, then an edge register. rise=TCK rising, fall=TCK falling, each a single-CLK pulse.
- TAP: transitions only on rise, using synchronized TMS, per IEEE 1149.1. Five rises with TMS=1 reach Test-Logic-Reset from any state.
- Test-Logic-Reset sets IR=IDCODE only. Pending and backend state are untouched.
- Shifting happens on rise while in Shift-xR: shift right, TDI enters at MSB of the selected length. TDO<=sr[0] on fall; held otherwise.
- Capture-IR loads 4'b0001.
- IR decode: 8=ABORT (35b), A=DPACC (35b), B=APACC (35b), E=IDCODE (32b), other=BYPASS (1b, captures 0).
- Capture-DR for DPACC/APACC:
  - pending=1 → {result, 3'b001} (WAIT).
  - pending=0 → {result, 3'b010} (OK/FAULT).
  - result is the read data of the last completed read; it is left unchanged by writes.
- Update-DR for DPACC/APACC, scan is {data[34:3], A[2:1], RnW[0]}:
  - pending=0 → latch REQ_* and set REQ_VALID, pending=1.
  - pending=1 → scan ignored (host retries).
- Backend handshake:
  - REQ_VALID holds with stable fields until REQ_READY, then drops the next cycle.
  - pending clears on RSP_VALID.
  - On a read, result<=RSP_RDATA. On RSP_ERR, STICKY_ERR<=1 and result is unchanged.
  - RSP_VALID with pending=0 is ignored.
- Same-cycle RSP_VALID and Capture-DR: the response is applied first, so capture sees pending=0 and the new result.
- Update-DR for ABORT:
  - Pulse ABORT_VALID with scan[7:3].
  - If scan[3]=1 (DAPABORT): pending=0, REQ_VALID=0. If the request was already accepted, set discard=1 so the next RSP_VALID is dropped (no result or STICKY_ERR update).
  - If scan[5]=1, clear STICKY_ERR.
- RESET mid-scan or mid-request: everything returns to reset values immediately. Any later RSP_VALID is ignored because pending=0.

Decomposition:
- Package jtag_dp_pkg holds:
  - tap_state_t enum (16 states);
  - IR codes IR_ABORT=4'h8, IR_DPACC=4'hA, IR_APACC=4'hB, IR_IDCODE=4'hE, IR_BYPASS=4'hF;
  - ACK codes ACK_OK=3'b010, ACK_WAIT=3'b001;
  - DR lengths.
- One sub-module, jtag_tap_fsm: synchronizer, edge detect, and TAP state machine. It outputs the state plus capture/shift/update strobes. The top level holds IR, DR and the backend logic.

Test Plan:
- TLR (TMS=1 ×5), then a 32-bit DR scan → TDO returns 32'h4BA00477 LSB-first; IR still 4'hE.
- Scan IR=4'hA, DR {0x12345678,2'b01,1'b0} → REQ addr=1, wdata 0x12345678, RNW=0. Backend answers after 2 cycles. Next DR scan captures ACK 3'b010.
- DPACC read addr=3 with backend data 0xCAFEF00D → the following scan returns ACK 010 and bits[34:3]=0xCAFEF00D.
- Hold RSP_VALID off for 200 CLK and rescan → ACK 3'b001 and no second REQ_VALID. After the response, the rescan gives 010.
- Pending request, then IR=8 with DR 35'h8 (DAPABORT) → ABORT_VALID with data 5'h01; a later RSP_VALID is discarded; the next DPACC capture gives 010. RSP_ERR sets STICKY_ERR; ABORT with 35'h20 clears it.
- BYPASS (IR=4'h5): 8 bits of TDI emerge on TDO one TCK later. RESET asserted mid Shift-DR → TAP in Test-Logic-Reset, TDO_OE=0, IR=4'hE.

Source files
------------

// File: rtl/jtag_dp_pkg.sv
// Shared types and constants for the JTAG-DP responder.
package jtag_dp_pkg;

  typedef enum logic [3:0] {
    TLR        = 4'd0,
    RTI        = 4'd1,
    SEL_DR     = 4'd2,
    CAPTURE_DR = 4'd3,
    SHIFT_DR   = 4'd4,
    EXIT1_DR   = 4'd5,
    PAUSE_DR   = 4'd6,
    EXIT2_DR   = 4'd7,
    UPDATE_DR  = 4'd8,
    SEL_IR     = 4'd9,
    CAPTURE_IR = 4'd10,
    SHIFT_IR   = 4'd11,
    EXIT1_IR   = 4'd12,
    PAUSE_IR   = 4'd13,
    EXIT2_IR   = 4'd14,
    UPDATE_IR  = 4'd15
  } tap_state_t;

  localparam logic [3:0] IR_ABORT   = 4'h8;
  localparam logic [3:0] IR_DPACC   = 4'hA;
  localparam logic [3:0] IR_APACC   = 4'hB;
  localparam logic [3:0] IR_IDCODE  = 4'hE;
  localparam logic [3:0] IR_BYPASS  = 4'hF;
  localparam logic [3:0] IR_CAPTURE = 4'b0001;

  localparam logic [2:0] ACK_OK   = 3'b010;
  localparam logic [2:0] ACK_WAIT = 3'b001;

  localparam logic [5:0] IR_LEN     = 6'd4;
  localparam logic [5:0] DR_LEN_ACC = 6'd35;
  localparam logic [5:0] DR_LEN_ID  = 6'd32;
  localparam logic [5:0] DR_LEN_BYP = 6'd1;

  // Length of the data register selected by an instruction.
  function automatic logic [5:0] dr_len(input logic [3:0] ir);
    case (ir)
      IR_ABORT, IR_DPACC, IR_APACC: dr_len = DR_LEN_ACC;
      IR_IDCODE:                    dr_len = DR_LEN_ID;
      default:                      dr_len = DR_LEN_BYP;
    endcase
  endfunction

endpackage

// File: rtl/jtag_dp_tap_if.sv
// Backend register-request / response port of the JTAG-DP responder.
interface jtag_dp_tap_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_APNDP;
  logic [1:0]  REQ_ADDR;
  logic        REQ_RNW;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_APNDP, REQ_ADDR, REQ_RNW, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_APNDP, REQ_ADDR, REQ_RNW, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// Oversampled JTAG pins, TCK edge detection and the IEEE 1149.1 TAP controller.
module jtag_tap_fsm
  import jtag_dp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output tap_state_t state,
  output logic       fall,
  output logic       tdi_s,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       tlr_entry
);

  logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
  logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
  logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
  logic                   tck_prev_q, tck_prev_d;
  logic                   tck_s, tms_s, rise;
  tap_state_t             state_q, state_d;

  // Synchronizer chains, TCK history and TAP state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_prev_q <= 1'b0;
      state_q    <= TLR;
    end else begin
      tck_sync_q <= tck_sync_d;
      tms_sync_q <= tms_sync_d;
      tdi_sync_q <= tdi_sync_d;
      tck_prev_q <= tck_prev_d;
      state_q    <= state_d;
    end
  end

  // Advance synchronizers, detect TCK edges, step the TAP on each rise.
  always_comb begin
    tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], tck};
    tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], tms};
    tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], tdi};
    tck_s      = tck_sync_q[SYNC_STAGES-1];
    tms_s      = tms_sync_q[SYNC_STAGES-1];
    tdi_s      = tdi_sync_q[SYNC_STAGES-1];
    tck_prev_d = tck_s;
    rise       = tck_s & ~tck_prev_q;
    fall       = ~tck_s & tck_prev_q;
    state_d    = state_q;
    if (rise) begin
      case (state_q)
        TLR:        state_d = tms_s ? TLR      : RTI;
        RTI:        state_d = tms_s ? SEL_DR   : RTI;
        SEL_DR:     state_d = tms_s ? SEL_IR   : CAPTURE_DR;
        CAPTURE_DR: state_d = tms_s ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:   state_d = tms_s ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:   state_d = tms_s ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:   state_d = tms_s ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:   state_d = tms_s ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:  state_d = tms_s ? SEL_DR   : RTI;
        SEL_IR:     state_d = tms_s ? TLR      : CAPTURE_IR;
        CAPTURE_IR: state_d = tms_s ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:   state_d = tms_s ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:   state_d = tms_s ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:   state_d = tms_s ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:   state_d = tms_s ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:  state_d = tms_s ? SEL_DR   : RTI;
        default:    state_d = TLR;
      endcase
    end else begin
      state_d = state_q;
    end
    capture_ir = rise && (state_q == CAPTURE_IR);
    shift_ir   = rise && (state_q == SHIFT_IR);
    update_ir  = rise && (state_q == UPDATE_IR);
    capture_dr = rise && (state_q == CAPTURE_DR);
    shift_dr   = rise && (state_q == SHIFT_DR);
    update_dr  = rise && (state_q == UPDATE_DR);
    tlr_entry  = rise && (state_d == TLR) && (state_q != TLR);
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_dp_tap.sv
// JTAG-DP responder: IR/DR scan chains and the DPACC/APACC/ABORT backend.
module jtag_dp_tap
  import jtag_dp_pkg::*;
#(
  parameter logic [31:0] IDCODE      = 32'h4BA00477,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_OE,
  jtag_dp_tap_if.master       bus,
  output logic                ABORT_VALID,
  output logic [4:0]          ABORT_DATA,
  output logic                STICKY_ERR,
  output logic                TAP_RESET
);

  tap_state_t  state;
  logic        fall, tdi_s, capture_ir, shift_ir, update_ir;
  logic        capture_dr, shift_dr, update_dr, tlr_entry;
  logic [5:0]  shift_len;
  logic        accepted;

  logic [3:0]  ir_q, ir_d;
  logic [34:0] sr_q, sr_d;
  logic        tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic        req_valid_q, req_valid_d, req_apndp_q, req_apndp_d;
  logic [1:0]  req_addr_q, req_addr_d;
  logic        req_rnw_q, req_rnw_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic        pending_q, pending_d, discard_q, discard_d;
  logic [31:0] result_q, result_d;
  logic        abort_valid_q, abort_valid_d;
  logic [4:0]  abort_data_q, abort_data_d;
  logic        sticky_q, sticky_d, tap_reset_q, tap_reset_d;

  jtag_tap_fsm #(.SYNC_STAGES(SYNC_STAGES)) u_fsm (
    .clk(CLK), .rst(RESET), .tck(TCK), .tms(TMS), .tdi(TDI),
    .state(state), .fall(fall), .tdi_s(tdi_s),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .tlr_entry(tlr_entry)
  );

  // Register all scan, backend and output state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_q <= IR_IDCODE;     sr_q <= '0;
      tdo_q <= 1'b0;         tdo_oe_q <= 1'b0;
      req_valid_q <= 1'b0;   req_apndp_q <= 1'b0;  req_addr_q <= 2'd0;
      req_rnw_q <= 1'b0;     req_wdata_q <= '0;
      pending_q <= 1'b0;     discard_q <= 1'b0;    result_q <= '0;
      abort_valid_q <= 1'b0; abort_data_q <= 5'd0;
      sticky_q <= 1'b0;      tap_reset_q <= 1'b0;
    end else begin
      ir_q <= ir_d;          sr_q <= sr_d;
      tdo_q <= tdo_d;        tdo_oe_q <= tdo_oe_d;
      req_valid_q <= req_valid_d; req_apndp_q <= req_apndp_d; req_addr_q <= req_addr_d;
      req_rnw_q <= req_rnw_d;     req_wdata_q <= req_wdata_d;
      pending_q <= pending_d;     discard_q <= discard_d;     result_q <= result_d;
      abort_valid_q <= abort_valid_d; abort_data_q <= abort_data_d;
      sticky_q <= sticky_d;       tap_reset_q <= tap_reset_d;
    end
  end

  // Backend handshake first, then scan actions so capture sees the response.
  always_comb begin
    ir_d = ir_q;  sr_d = sr_q;  tdo_d = tdo_q;
    req_valid_d = req_valid_q;  req_apndp_d = req_apndp_q;  req_addr_d = req_addr_q;
    req_rnw_d = req_rnw_q;      req_wdata_d = req_wdata_q;
    pending_d = pending_q;      discard_d = discard_q;      result_d = result_q;
    sticky_d = sticky_q;
    abort_valid_d = 1'b0;
    abort_data_d  = 5'd0;
    tap_reset_d   = tlr_entry;
    tdo_oe_d      = (state == SHIFT_DR) || (state == SHIFT_IR);
    shift_len     = shift_ir ? IR_LEN : dr_len(ir_q);
    accepted      = 1'b0;

    if (req_valid_q && bus.REQ_READY) begin
      req_valid_d = 1'b0;
    end else begin
      req_valid_d = req_valid_q;
    end

    // A response after DAPABORT belongs to the aborted request: swallow it.
    if (bus.RSP_VALID) begin
      if (discard_q) begin
        discard_d = 1'b0;
      end else if (pending_q) begin
        pending_d = 1'b0;
        if (bus.RSP_ERR) begin
          sticky_d = 1'b1;
        end else if (req_rnw_q) begin
          result_d = bus.RSP_RDATA;
        end else begin
          result_d = result_q;
        end
      end else begin
        pending_d = pending_q;
      end
    end else begin
      pending_d = pending_q;
    end

    if (state == TLR) begin
      ir_d = IR_IDCODE;
    end else if (update_ir) begin
      ir_d = sr_q[3:0];
    end else begin
      ir_d = ir_q;
    end

    if (capture_ir) begin
      sr_d = {31'd0, IR_CAPTURE};
    end else if (capture_dr) begin
      case (ir_q)
        IR_DPACC, IR_APACC: sr_d = {result_d, pending_d ? ACK_WAIT : ACK_OK};
        IR_IDCODE:          sr_d = {3'd0, IDCODE};
        default:            sr_d = '0;
      endcase
    end else if (shift_ir || shift_dr) begin
      sr_d = sr_q >> 1;
      sr_d[shift_len - 6'd1] = tdi_s;
    end else begin
      sr_d = sr_q;
    end

    if (fall) begin
      tdo_d = sr_q[0];
    end else begin
      tdo_d = tdo_q;
    end

    if (update_dr) begin
      case (ir_q)
        IR_DPACC, IR_APACC: begin
          if (!pending_d) begin
            req_valid_d = 1'b1;
            req_apndp_d = (ir_q == IR_APACC);
            req_addr_d  = sr_q[2:1];
            req_rnw_d   = sr_q[0];
            req_wdata_d = sr_q[34:3];
            pending_d   = 1'b1;
          end else begin
            pending_d   = 1'b1;
          end
        end
        IR_ABORT: begin
          abort_valid_d = 1'b1;
          abort_data_d  = sr_q[7:3];
          if (sr_q[3]) begin
            // Already handed to the backend: its response will still arrive.
            accepted    = pending_d && !req_valid_d;
            discard_d   = accepted;
            pending_d   = 1'b0;
            req_valid_d = 1'b0;
          end else begin
            discard_d   = discard_q;
          end
          if (sr_q[5]) begin
            sticky_d = 1'b0;
          end else begin
            sticky_d = sticky_d;
          end
        end
        default: begin
          pending_d = pending_d;
        end
      endcase
    end else begin
      pending_d = pending_d;
    end
  end

  assign TDO           = tdo_q;
  assign TDO_OE        = tdo_oe_q;
  assign bus.REQ_VALID = req_valid_q;
  assign bus.REQ_APNDP = req_apndp_q;
  assign bus.REQ_ADDR  = req_addr_q;
  assign bus.REQ_RNW   = req_rnw_q;
  assign bus.REQ_WDATA = req_wdata_q;
  assign ABORT_VALID   = abort_valid_q;
  assign ABORT_DATA    = abort_data_q;
  assign STICKY_ERR    = sticky_q;
  assign TAP_RESET     = tap_reset_q;

endmodule

// File: tb/tb_jtag_dp_tap.sv
// Directed bench for jtag_dp_tap: bit-banged JTAG host plus a hand-driven backend.
module tb_jtag_dp_tap;
  import jtag_dp_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, TCK, TMS, TDI;
  logic        TDO, TDO_OE, ABORT_VALID, STICKY_ERR, TAP_RESET;
  logic [4:0]  ABORT_DATA;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          abort_cnt = 0;
  int          tlr_cnt   = 0;
  int          tlr_before;
  logic [4:0]  abort_last = 5'd0;
  logic [34:0] dout;
  logic [3:0]  irout;
  logic        b;

  jtag_dp_tap_if bus();

  jtag_dp_tap #(.IDCODE(32'h4BA00477), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .TCK(TCK), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .TDO_OE(TDO_OE), .bus(bus),
    .ABORT_VALID(ABORT_VALID), .ABORT_DATA(ABORT_DATA),
    .STICKY_ERR(STICKY_ERR), .TAP_RESET(TAP_RESET)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ABORT_VALID) begin
      abort_cnt  <= abort_cnt + 1;
      abort_last <= ABORT_DATA;
    end
    if (TAP_RESET) tlr_cnt <= tlr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK period; TDO sampled just before the rising edge.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
    TMS = tms; TDI = tdi;
    repeat (6) @(negedge CLK);
    tdo = TDO;
    TCK = 1'b1;
    repeat (6) @(negedge CLK);
    TCK = 1'b0;
  endtask

  task automatic tap_reset();
    logic t;
    repeat (5) tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
    logic t;
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, v[i], t);
      o[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    repeat (6) @(negedge CLK);
  endtask

  task automatic scan_dr(input int n, input logic [34:0] d, output logic [34:0] o);
    logic t;
    o = '0;
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, d[i], t);
      o[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    repeat (6) @(negedge CLK);
  endtask

  task automatic accept_req(input string tag);
    int i;
    for (i = 0; i < 50 && bus.REQ_VALID !== 1'b1; i++) @(negedge CLK);
    check(tag, 64'(bus.REQ_VALID), 64'd1);
    bus.REQ_READY = 1'b1;
    @(negedge CLK);
    bus.REQ_READY = 1'b0;
    @(negedge CLK);
  endtask

  task automatic rsp_pulse(input logic [31:0] rdata, input logic err);
    bus.RSP_VALID = 1'b1; bus.RSP_RDATA = rdata; bus.RSP_ERR = err;
    @(negedge CLK);
    bus.RSP_VALID = 1'b0; bus.RSP_RDATA = 32'd0; bus.RSP_ERR = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1; TCK = 1'b0; TMS = 1'b0; TDI = 1'b0;
    bus.REQ_READY = 1'b0; bus.RSP_VALID = 1'b0; bus.RSP_RDATA = 32'd0; bus.RSP_ERR = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tdo", 64'(TDO), 64'd0);
    check("rst_tdo_oe", 64'(TDO_OE), 64'd0);
    check("rst_req_valid", 64'(bus.REQ_VALID), 64'd0);
    check("rst_sticky", 64'(STICKY_ERR), 64'd0);
    check("rst_abort", 64'({ABORT_VALID, ABORT_DATA}), 64'd0);
    check("rst_state", 64'(dut.u_fsm.state_q), 64'(TLR));
    check("rst_ir", 64'(dut.ir_q), 64'hE);
    RESET = 1'b0;
    @(negedge CLK);

    // IDCODE after TLR
    tap_reset();
    check("tlr_no_pulse_from_tlr", 64'(tlr_cnt), 64'd0);
    scan_dr(32, 35'd0, dout);
    check("idcode", 64'(dout[31:0]), 64'h4BA00477);
    check("ir_still_idcode", 64'(dut.ir_q), 64'hE);

    // DPACC write addr 1
    scan_ir(4'hA, irout);
    check("ir_capture", 64'(irout), 64'h1);
    scan_dr(35, {32'h12345678, 2'b01, 1'b0}, dout);
    check("first_ack", 64'(dout), 64'h2);
    check("wr_req_fields", 64'({bus.REQ_APNDP, bus.REQ_ADDR, bus.REQ_RNW, bus.REQ_WDATA}),
          64'({1'b0, 2'b01, 1'b0, 32'h12345678}));
    accept_req("wr_req_valid");
    check("wr_req_drop", 64'(bus.REQ_VALID), 64'd0);
    rsp_pulse(32'hDEADBEEF, 1'b0);

    // DPACC read addr 3; write left result at 0
    scan_dr(35, {32'd0, 2'b11, 1'b1}, dout);
    check("ack_after_write", 64'(dout), 64'h2);
    check("rd_req_fields", 64'({bus.REQ_ADDR, bus.REQ_RNW}), 64'({2'b11, 1'b1}));
    accept_req("rd_req_valid");
    rsp_pulse(32'hCAFEF00D, 1'b0);
    scan_dr(35, {32'd0, 2'b11, 1'b1}, dout);
    check("rd_result", 64'(dout), 64'({32'hCAFEF00D, 3'b010}));

    // WAIT while backend is slow
    accept_req("slow_req_valid");
    repeat (200) @(negedge CLK);
    scan_dr(35, {32'd0, 2'b11, 1'b1}, dout);
    check("wait_ack", 64'(dout), 64'({32'hCAFEF00D, 3'b001}));
    check("no_second_req", 64'(bus.REQ_VALID), 64'd0);
    rsp_pulse(32'h11112222, 1'b0);
    scan_dr(35, {32'd0, 2'b11, 1'b1}, dout);
    check("ok_after_wait", 64'(dout), 64'({32'h11112222, 3'b010}));
    accept_req("pre_abort_req");

    // DAPABORT with an accepted request outstanding
    scan_ir(4'h8, irout);
    scan_dr(35, 35'h8, dout);
    check("abort_count", 64'(abort_cnt), 64'd1);
    check("abort_data", 64'(abort_last), 64'h01);
    check("abort_req_valid", 64'(bus.REQ_VALID), 64'd0);
    rsp_pulse(32'h99999999, 1'b1);
    check("discard_sticky", 64'(STICKY_ERR), 64'd0);
    scan_ir(4'hA, irout);
    scan_dr(35, {32'd0, 2'b11, 1'b1}, dout);
    check("ack_after_abort", 64'(dout), 64'({32'h11112222, 3'b010}));
    accept_req("err_req_valid");
    rsp_pulse(32'h55555555, 1'b1);
    check("sticky_set", 64'(STICKY_ERR), 64'd1);
    scan_ir(4'h8, irout);
    scan_dr(35, 35'h20, dout);
    check("sticky_clear", 64'(STICKY_ERR), 64'd0);
    check("abort2_data", 64'({abort_cnt[3:0], abort_last}), 64'({4'd2, 5'h04}));

    // BYPASS
    scan_ir(4'h5, irout);
    scan_dr(9, {27'd0, 8'hA5}, dout);
    check("bypass", 64'(dout[8:0]), 64'({8'hA5, 1'b0}));

    // RESET in the middle of Shift-DR
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b1, b); tck_cycle(1'b0, 1'b1, b);
    check("shift_oe", 64'(TDO_OE), 64'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid_rst_state", 64'(dut.u_fsm.state_q), 64'(TLR));
    check("mid_rst_oe", 64'(TDO_OE), 64'd0);
    check("mid_rst_ir", 64'(dut.ir_q), 64'hE);

    // TAP_RESET pulse on entry to TLR from Run-Test/Idle
    tck_cycle(1'b0, 1'b0, b);
    scan_ir(4'hA, irout);
    tlr_before = tlr_cnt;
    tap_reset();
    check("tap_reset_pulse", 64'(tlr_cnt - tlr_before), 64'd1);
    check("tlr_ir", 64'(dut.ir_q), 64'hE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
